// File: rtl/cbsc_mac_array.sv
// Counter-based stochastic-computing MAC array: CHANNELS lanes of x*w via bit-reversed SNG streams.
// Optional macro CBSC_MAC_ACCUM_EN: accumulate into q with saturation and acc_clr support.
module cbsc_mac_array #(
  parameter int unsigned WIDTH     = 7,
  parameter int unsigned CHANNELS  = 4,
  parameter int unsigned ACC_WIDTH = WIDTH + $clog2(CHANNELS)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [CHANNELS*WIDTH-1:0]    x,
  input  logic [CHANNELS*WIDTH-1:0]    w,
  input  logic                         acc_clr,
  output logic                         busy,
  output logic                         done,
  output logic [ACC_WIDTH-1:0]         q
);

  typedef enum logic [1:0] {IDLE, RUN, SUM} state_t;

  state_t                            state_q, state_d;
  logic [CHANNELS-1:0][WIDTH-1:0]    x_r, d_r, p_r;
  logic [WIDTH-1:0]                  c_r, c_rev_c;
  logic [CHANNELS-1:0]               s_c;
  logic                              any_w_c, last_c;
  logic [ACC_WIDTH-1:0]              sum_c;
  logic                              busy_d, done_d;

  // Bit-reversed sequence value shared by all stream generators
  always_comb begin
    c_rev_c = '0;
    for (int unsigned b = 0; b < WIDTH; b++) begin
      c_rev_c[b] = c_r[WIDTH-1-b];
    end
  end

  // Per-lane stream bits, start/finish detection and product sum
  always_comb begin
    s_c     = '0;
    any_w_c = 1'b0;
    last_c  = 1'b1;
    sum_c   = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      s_c[i]  = x_r[i] > c_rev_c;
      any_w_c = any_w_c | (w[i*WIDTH +: WIDTH] != '0);
      last_c  = last_c & (d_r[i] <= WIDTH'(1));
      sum_c   = sum_c + ACC_WIDTH'(p_r[i]);
    end
  end

  // Next-state and registered-output decode
  always_comb begin
    state_d = state_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      IDLE:    if (start) state_d = any_w_c ? RUN : SUM;
      RUN:     if (last_c) state_d = SUM;
      SUM:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_q == SUM);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

  // Operand latch, down counters, product counters and sequence counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x_r <= '0;
      d_r <= '0;
      p_r <= '0;
      c_r <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            x_r <= x;
            d_r <= w;
            p_r <= '0;
            c_r <= '0;
          end
        end
        RUN: begin
          for (int unsigned i = 0; i < CHANNELS; i++) begin
            if (d_r[i] != '0) begin
              p_r[i] <= p_r[i] + WIDTH'(s_c[i]);
              d_r[i] <= d_r[i] - WIDTH'(1);
            end
          end
          c_r <= c_r + WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef CBSC_MAC_ACCUM_EN
  logic [ACC_WIDTH:0] acc_c;
  assign acc_c = (ACC_WIDTH+1)'(q) + (ACC_WIDTH+1)'(sum_c);

  // Saturating accumulate; a clear coinciding with SUM leaves just this run's sum
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (state_q == SUM) begin
      if (acc_clr) begin
        q <= sum_c;
      end else begin
        q <= acc_c[ACC_WIDTH] ? '1 : acc_c[ACC_WIDTH-1:0];
      end
    end else if (acc_clr) begin
      q <= '0;
    end
  end
`else
  logic unused_acc_clr;
  assign unused_acc_clr = acc_clr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (state_q == SUM) begin
      q <= sum_c;
    end
  end
`endif

endmodule

// File: tb/tb_cbsc_mac_array.sv
// Self-checking bench for cbsc_mac_array: behavioural stream-count model plus directed literal checks.
module tb_cbsc_mac_array;
  localparam int unsigned W    = 7;
  localparam int unsigned CH   = 4;
  localparam int unsigned AW   = W + $clog2(CH);
  localparam int unsigned QMAX = (1 << AW) - 1;
`ifdef CBSC_MAC_ACCUM_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst, start, acc_clr, busy, done;
  logic [CH*W-1:0] x, w;
  logic [AW-1:0]   q;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  bit          m_busy = 1'b0;
  bit          m_done = 1'b0;
  int unsigned m_q    = 0;
  int unsigned m_left = 0;
  int unsigned m_res  = 0;

  always #5 clk = ~clk;

  cbsc_mac_array #(.WIDTH(W), .CHANNELS(CH), .ACC_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .x(x), .w(w),
    .acc_clr(acc_clr), .busy(busy), .done(done), .q(q)
  );

  task automatic chk(input string name, input int unsigned act, input int unsigned exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: reverse the digits of c in base 2 arithmetically
  function automatic int unsigned bitrev(input int unsigned v);
    int unsigned r, t;
    r = 0;
    t = v;
    for (int b = 0; b < int'(W); b++) begin
      r = r * 2 + t % 2;
      t = t / 2;
    end
    return r;
  endfunction

  // Ones in the first wv stream positions of a lane with value xv
  function automatic int unsigned lane_prod(input int unsigned xv, input int unsigned wv);
    int unsigned cnt;
    cnt = 0;
    for (int unsigned c = 0; c < wv; c++) begin
      if (xv > bitrev(c)) cnt++;
    end
    return cnt;
  endfunction

  function automatic int unsigned exp_sum(input logic [CH*W-1:0] xv, input logic [CH*W-1:0] wv);
    int unsigned s;
    s = 0;
    for (int i = 0; i < int'(CH); i++) begin
      s += lane_prod(32'(xv[i*W +: W]), 32'(wv[i*W +: W]));
    end
    return s;
  endfunction

  function automatic int unsigned max_w(input logic [CH*W-1:0] wv);
    int unsigned m;
    m = 0;
    for (int i = 0; i < int'(CH); i++) begin
      if (32'(wv[i*W +: W]) > m) m = 32'(wv[i*W +: W]);
    end
    return m;
  endfunction

  function automatic logic [CH*W-1:0] fill(input int unsigned v);
    logic [CH*W-1:0] r;
    r = '0;
    for (int i = 0; i < int'(CH); i++) r[i*W +: W] = W'(v);
    return r;
  endfunction

  function automatic logic [W-1:0] rand_lane();
    case ($urandom_range(0, 4))
      0:       return '0;
      1:       return W'(1);
      2:       return W'(127);
      3:       return W'($urandom_range(0, 15));
      default: return W'($urandom_range(0, 127));
    endcase
  endfunction

  // Transaction-level model: an accepted start finishes M+1 edges later
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_q    = 0;
      m_left = 0;
    end else begin
      m_done = 1'b0;
      if (m_left != 0) begin
        m_left--;
        if (m_left == 0) begin
          m_busy = 1'b0;
          m_done = 1'b1;
          if (!ACC_EN || acc_clr) m_q = m_res;
          else m_q = (m_q + m_res > QMAX) ? QMAX : m_q + m_res;
        end else if (ACC_EN && acc_clr) begin
          m_q = 0;
        end
      end else begin
        if (ACC_EN && acc_clr) m_q = 0;
        if (start) begin
          m_res  = exp_sum(x, w);
          m_left = max_w(w) + 1;
          m_busy = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", 32'(busy), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("q",    32'(q),    m_q);
  end

  task automatic clear_acc();
    @(posedge clk); #1 acc_clr = 1'b1;
    @(posedge clk); #1 acc_clr = 1'b0;
  endtask

  // Issue one start; count negedges until done and check latency and result literals
  task automatic run_op(input logic [CH*W-1:0] xv, input logic [CH*W-1:0] wv,
                        input int unsigned exp_q, input int unsigned exp_n, input bit perturb);
    int unsigned n;
    bit          got;
    @(posedge clk); #1 start = 1'b1; x = xv; w = wv;
    @(posedge clk); #1 start = 1'b0;
    n   = 0;
    got = 1'b0;
    while (n < 400 && !got) begin
      @(negedge clk);
      n++;
      if (done) got = 1'b1;
      else if (perturb && n >= 3 && n <= 6) begin
        start = 1'b1;
        x = (CH*W)'($urandom);
        w = (CH*W)'($urandom);
      end else if (perturb && n == 7) begin
        start = 1'b0;
      end
    end
    chk("op_latency", n, exp_n);
    chk("op_q", 32'(q), exp_q);
  endtask

  initial begin
    logic [CH*W-1:0] lane0;
    rst = 1'b1; start = 1'b0; acc_clr = 1'b0; x = '0; w = '0;
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_q", 32'(q), 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    lane0 = '0;
    lane0[W-1:0] = W'(127);
    chk("model_64", exp_sum(fill(64), fill(64)), 128);
    chk("model_127", exp_sum(fill(127), fill(127)), 508);
    chk("model_lane0", exp_sum(fill(0), lane0), 0);
    chk("model_x1w3", lane_prod(1, 3), 1);
    chk("model_x64w2", lane_prod(64, 2), 1);
    chk("model_x127w64", lane_prod(127, 64), 64);

    clear_acc(); run_op(fill(64), fill(64), 128, 66, 1'b0);
    clear_acc(); run_op(fill(127), fill(127), 508, 129, 1'b0);
    clear_acc(); run_op((CH*W)'($urandom), fill(0), 0, 2, 1'b0);
    clear_acc(); run_op({(CH*W-W)'($urandom), W'(0)}, lane0, 0, 129, 1'b0);
    clear_acc(); run_op(fill(64), fill(64), 128, 66, 1'b1);

    // Abort mid-run with reset, then resume normally
    @(posedge clk); #1 start = 1'b1; x = fill(64); w = fill(64);
    @(posedge clk); #1 start = 1'b0;
    repeat (20) @(negedge clk);
    #1 rst = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_q", 32'(q), 0);
    @(posedge clk); #1 rst = 1'b1;
    run_op(fill(64), fill(64), 128, 66, 1'b0);

    clear_acc();
    run_op(fill(127), fill(127), 508, 129, 1'b0);
`ifdef CBSC_MAC_ACCUM_EN
    run_op(fill(127), fill(127), 511, 129, 1'b0);
    clear_acc();
    @(negedge clk);
    chk("acc_clr_q", 32'(q), 0);
`else
    run_op(fill(127), fill(127), 508, 129, 1'b0);
    clear_acc();
    @(negedge clk);
    chk("acc_clr_ignored_q", 32'(q), 508);
`endif

    // Free-running random traffic; the per-cycle compare carries the checking
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk); #1;
      start   = ($urandom_range(0, 3) == 0);
      acc_clr = ($urandom_range(0, 15) == 0);
      x       = (CH*W)'($urandom);
      for (int i = 0; i < int'(CH); i++) w[i*W +: W] = rand_lane();
    end
    @(posedge clk); #1 start = 1'b0; acc_clr = 1'b0;
    repeat (140) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
